// File: rtl/rv32i_types.sv
// RV32I memory-stage types and access-width helpers shared by the MEM controller and aligner.
// Declarations only: no latency, no flow control.
package rv32i_types;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

    typedef enum logic [1:0] {
        W_BYTE = 2'd0,
        W_HALF = 2'd1,
        W_WORD = 2'd2
    } access_width_t;

    // Any funct3 code outside the defined load/store set is handled as a word access.
    function automatic access_width_t access_width(input logic is_store, input logic [2:0] f3);
        access_width_t w;
        w = W_WORD;
        if (is_store) begin
            case (f3)
                SB:      w = W_BYTE;
                SH:      w = W_HALF;
                default: w = W_WORD;
            endcase
        end else begin
            case (f3)
                LB, LBU: w = W_BYTE;
                LH, LHU: w = W_HALF;
                default: w = W_WORD;
            endcase
        end
        return w;
    endfunction

    function automatic logic [3:0] byte_enables(input access_width_t w, input logic [1:0] off);
        logic [3:0] be;
        case (w)
            W_BYTE:  be = 4'b0001 << off;
            W_HALF:  be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic is_misaligned(input access_width_t w, input logic [1:0] off);
        logic mis;
        case (w)
            W_HALF:  mis = off[0];
            W_WORD:  mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [31:0] replicate_wdata(input access_width_t w, input logic [31:0] d);
        logic [31:0] r;
        case (w)
            W_BYTE:  r = {4{d[7:0]}};
            W_HALF:  r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Selects the addressed byte/half lane of a memory read word and sign/zero extends it.
// Purely combinational (zero latency); no flow control.
module mem_align (
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);
    import rv32i_types::*;

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (offset_i)
            2'd0:    byte_lane = rdata_i[7:0];
            2'd1:    byte_lane = rdata_i[15:8];
            2'd2:    byte_lane = rdata_i[23:16];
            default: byte_lane = rdata_i[31:24];
        endcase
        half_lane = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        case (funct3_i)
            LB:      data_o = {{24{byte_lane[7]}}, byte_lane};
            LH:      data_o = {{16{half_lane[15]}}, half_lane};
            LBU:     data_o = {24'd0, byte_lane};
            LHU:     data_o = {16'd0, half_lane};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory controller: latches one load/store, holds the request until dmem_resp, then releases the pipeline.
// Latency >= 3 cycles (IDLE, ACCESS.., DONE); stall backpressures all pipeline registers until the DONE cycle.
module mem_stage_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        dmem_resp,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_address,
    output logic [3:0]  dmem_byte_enable,
    output logic [31:0] dmem_wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        misaligned
);
    import rv32i_types::*;

    mem_state_t    state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [1:0]    off_q, off_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [2:0]    funct3_q, funct3_d;
    logic          store_q, store_d;
    logic [31:0]   load_q, load_d;

    logic          req_vld;
    logic          req_mis;
    access_width_t req_width;
    logic [31:0]   aligned_rdata;

    // A simultaneous read+write is a store.
    assign req_vld   = mem_read | mem_write;
    assign req_width = access_width(mem_write, funct3);
    assign req_mis   = is_misaligned(req_width, addr[1:0]);

    mem_align u_mem_align (
        .funct3_i (funct3_q),
        .offset_i (off_q),
        .rdata_i  (dmem_rdata),
        .data_o   (aligned_rdata)
    );

    assign dmem_address = addr_q;
    assign dmem_wdata   = wdata_q;

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        off_d            = off_q;
        be_d             = be_q;
        wdata_d          = wdata_q;
        funct3_d         = funct3_q;
        store_d          = store_q;
        load_d           = load_q;
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_byte_enable = 4'b0000;
        stall            = 1'b0;
        load_data        = 32'd0;
        misaligned       = 1'b0;

        case (state_q)
            IDLE: begin
                // rst_n gating keeps the combinational IDLE outputs quiet while reset is held.
                if (rst_n && req_vld) begin
                    if (req_mis) begin
                        misaligned = 1'b1;
                    end else begin
                        stall    = 1'b1;
                        addr_d   = {addr[31:2], 2'b00};
                        off_d    = addr[1:0];
                        be_d     = byte_enables(req_width, addr[1:0]);
                        wdata_d  = replicate_wdata(req_width, wdata);
                        funct3_d = funct3;
                        store_d  = mem_write;
                        state_d  = ACCESS;
                    end
                end
            end
            ACCESS: begin
                stall            = 1'b1;
                dmem_read        = ~store_q;
                dmem_write       = store_q;
                dmem_byte_enable = be_q;
                if (dmem_resp) begin
                    load_d  = store_q ? 32'd0 : aligned_rdata;
                    state_d = DONE;
                end
            end
            DONE: begin
                load_data = load_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= 32'd0;
            off_q    <= 2'd0;
            be_q     <= 4'd0;
            wdata_q  <= 32'd0;
            funct3_q <= 3'd0;
            store_q  <= 1'b0;
            load_q   <= 32'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            off_q    <= off_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            store_q  <= store_d;
            load_q   <= load_d;
        end
    end

endmodule
